radix6_out_serializer: RTL and testbench
========================================

Name: radix6_out_serializer

Overview:
- Collects one parallel radix-6 butterfly result frame (6 complex IEEE-754 single-precision points a..f) from the radix_6_top output side.
- Streams the frame out one complex point per cycle over a valid/ready handshake, feeding the downstream memory/twiddle stage.
- Ping-pong double buffer: a new frame can be captured while the previous one drains.
- Data is bit-transparent; no floating-point arithmetic is performed.

Parameters:
- DATA_W, 32, width of each real/imag word (IEEE-754 single).
- FRAME_W, 8, width of the emitted frame counter tag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a..f lanes hold a valid frame.
- in_ready  output  1  block can accept a frame this cycle.
- a_re, b_re, c_re, d_re, e_re, f_re  input  DATA_W each  real parts of points 0..5.
- a_img, b_img, c_img, d_img, e_img, f_img  input  DATA_W each  imaginary parts of points 0..5.
- out_valid  output  1  out_re/out_img/out_idx are valid.
- out_ready  input  1  downstream accepts the current point.
- out_re  output  DATA_W  real part of the current point.
- out_img  output  DATA_W  imaginary part of the current point.
- out_idx  output  3  point index 0..5 (a=0 … f=5).
- out_last  output  1  high when out_idx==5 and out_valid.
- out_frame  output  FRAME_W  sequence number of the frame being emitted.

Behaviour:
- Reset (async, rst=1):
  - Both bank full flags = 0; wr_bank = 0, rd_bank = 0, rd_idx = 0, frame counter = 0.
  - Storage cleared to 0.
  - Outputs: in_ready = 1 once reset releases; out_valid = 0, out_re = 0, out_img = 0, out_idx = 0, out_last = 0, out_frame = 0.
- Storage: 2 banks × 6 points × (re, img), registered.
- in_ready = !full[wr_bank], taken from registered state only. There is no combinational path from out_ready to in_ready.
- Capture on clk edge when in_valid && in_ready:
  - All 12 words are written into bank wr_bank.
  - full[wr_bank] is set and wr_bank toggles.
  - Input lanes are sampled only on this edge.
- Read side, per-bank state EMPTY/FULL, read FSM:
  - IDLE: full[rd_bank] == 0. out_valid = 0.
  - STREAM: out_valid = 1; out_re/out_img = bank[rd_bank][rd_idx] (mux of registers); out_idx = rd_idx.
  - On out_valid && out_ready with rd_idx < 5: rd_idx increments.
  - On the transfer with rd_idx == 5: rd_idx ← 0, full[rd_bank] ← 0, rd_bank toggles, out_frame increments (wraps modulo 2^FRAME_W). The FSM returns to IDLE if the other bank is empty; otherwise it stays in STREAM with no bubble.
- Latency: a frame captured at edge k gives out_valid = 1 in the cycle after edge k. Point 5 of that frame is first presented 5 cycles later if out_ready is held high.
- Throughput: sustained 1 frame per 6 cycles with out_ready = 1. in_ready is high at least 1 cycle in every 6.
- Backpressure: while out_valid && !out_ready, the outputs hold stable (same data, idx and frame tag).
- Simultaneous capture and last-point read on the same bank index:
  - The freeing bank is never the write target in the same cycle, because a full wr_bank keeps in_ready = 0.
  - The freed bank becomes writable from the next cycle.
- Both banks full: in_ready = 0 until the final point of the draining frame transfers.
- Reset mid-stream: the partial frame is discarded. After release the block is empty and out_valid = 0.
- Special values (NaN, Inf, denormals, -0) pass through unmodified.

Decomposition:
- Shared package radix6_pkg:
  - constant NPTS = 6.
  - constant IDX_W = 3.
  - typedef cplx_t {re, img}, each DATA_W.
  - index constants IDX_A..IDX_F = 0..5.
- One natural sub-module: radix6_frame_bank. It holds one bank with a write-all port and an indexed read mux, and is instantiated twice.
- Control (pointers, full flags, FSM, counters) lives in the top module.

Test Plan:
- Reset values:
  - Stimulus: assert rst mid-cycle with no clk edge.
  - Required response: out_valid = 0, out_re = 0, out_frame = 0 immediately; in_ready = 1 after release.
- Single frame:
  - Stimulus: a_re = 3f491a30, a_img = 4246570a, … f_re = bf15c290, f_img = 4246570a; out_ready = 1.
  - Required response: 6 consecutive beats, idx 0..5, exact words; out_last only on the f beat; out_frame = 0.
- Back-to-back frames:
  - Stimulus: 4 frames with in_valid held high; the second frame has a_re = c142a3d7.
  - Required response: in_ready drops after 2 captures; 24 beats with no bubbles; out_frame 0,1,2,3 in order.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles at idx 2 (c_re = c14c0000).
  - Required response: outputs hold c14c0000 / 4246570a, idx 2; streaming resumes with idx 3.
- Reset mid-stream:
  - Stimulus: assert rst at idx 3 of frame 1.
  - Required response: out_valid = 0 at once; the next frame is emitted from idx 0 with out_frame = 0.
- Frame wrap:
  - Stimulus: 256 frames.
  - Required response: out_frame wraps 255 → 0; special value 7fc00000 (NaN) passes unchanged.

Source files
------------

// File: rtl/radix6_out_serializer_pkg.sv
// Shared types and constants for the radix-6 output serializer.
// A frame is six complex points a..f, carried as raw IEEE-754 bit patterns.
package radix6_pkg;

  localparam int NPTS   = 6;
  localparam int IDX_W  = 3;
  localparam int CPLX_W = 32;

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] img;
  } cplx_t;

  localparam logic [IDX_W-1:0] IDX_A = 3'd0;
  localparam logic [IDX_W-1:0] IDX_B = 3'd1;
  localparam logic [IDX_W-1:0] IDX_C = 3'd2;
  localparam logic [IDX_W-1:0] IDX_D = 3'd3;
  localparam logic [IDX_W-1:0] IDX_E = 3'd4;
  localparam logic [IDX_W-1:0] IDX_F = 3'd5;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/radix6_frame_bank.sv
// One frame buffer: all six points written in a single cycle, one point read
// at a time through an index mux.
module radix6_frame_bank
  import radix6_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en_i,
  input  logic [NPTS-1:0][DATA_W-1:0]     wr_re_i,
  input  logic [NPTS-1:0][DATA_W-1:0]     wr_img_i,
  input  logic [IDX_W-1:0]                rd_idx_i,
  output logic [DATA_W-1:0]               rd_re_o,
  output logic [DATA_W-1:0]               rd_img_o
);

  logic [NPTS-1:0][DATA_W-1:0] re_q;
  logic [NPTS-1:0][DATA_W-1:0] img_q;

  // NOTE: the storage is reset like any other register so a freshly reset
  // block never presents stale data; it is small enough to be flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q  <= '0;
      img_q <= '0;
    end else if (wr_en_i) begin
      re_q  <= wr_re_i;
      img_q <= wr_img_i;
    end
  end

  always_comb begin
    rd_re_o  = '0;
    rd_img_o = '0;
    if (rd_idx_i <= IDX_F) begin
      rd_re_o  = re_q[rd_idx_i];
      rd_img_o = img_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/radix6_out_serializer.sv
// Ping-pong buffered serializer: captures a six-point complex frame in one
// cycle and emits it one point per cycle over a valid/ready handshake.
module radix6_out_serializer
  import radix6_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  a_re,
  input  logic [DATA_W-1:0]  b_re,
  input  logic [DATA_W-1:0]  c_re,
  input  logic [DATA_W-1:0]  d_re,
  input  logic [DATA_W-1:0]  e_re,
  input  logic [DATA_W-1:0]  f_re,
  input  logic [DATA_W-1:0]  a_img,
  input  logic [DATA_W-1:0]  b_img,
  input  logic [DATA_W-1:0]  c_img,
  input  logic [DATA_W-1:0]  d_img,
  input  logic [DATA_W-1:0]  e_img,
  input  logic [DATA_W-1:0]  f_img,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_re,
  output logic [DATA_W-1:0]  out_img,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic [FRAME_W-1:0] out_frame
);

  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  rd_state_e          state_q, state_d;

  logic capture;
  logic xfer;

  logic [NPTS-1:0][DATA_W-1:0] lane_re;
  logic [NPTS-1:0][DATA_W-1:0] lane_img;
  logic [DATA_W-1:0]           bank_re  [2];
  logic [DATA_W-1:0]           bank_img [2];

  // Element 0 is point a, element 5 is point f.
  assign lane_re  = {f_re,  e_re,  d_re,  c_re,  b_re,  a_re};
  assign lane_img = {f_img, e_img, d_img, c_img, b_img, a_img};

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = ~full_q[wr_bank_q];
  assign capture   = in_valid & in_ready;
  assign out_valid = (state_q == RD_STREAM);
  assign xfer      = out_valid & out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    radix6_frame_bank #(
      .DATA_W (DATA_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (capture && (wr_bank_q == 1'(b))),
      .wr_re_i  (lane_re),
      .wr_img_i (lane_img),
      .rd_idx_i (rd_idx_q),
      .rd_re_o  (bank_re[b]),
      .rd_img_o (bank_img[b])
    );
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    frame_d   = frame_q;
    state_d   = state_q;

    if (capture) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    case (state_q)
      // With both banks empty the write pointer equals the read pointer,
      // so any capture lands in the bank about to be read.
      RD_IDLE: begin
        if (capture) state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (xfer) begin
          if (rd_idx_q == IDX_F) begin
            rd_idx_d          = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_d           = frame_q + 1'b1;
            if (!full_q[~rd_bank_q] && !capture) state_d = RD_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      frame_q   <= '0;
      state_q   <= RD_IDLE;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
    end
  end

  assign out_re    = out_valid ? bank_re[rd_bank_q]  : '0;
  assign out_img   = out_valid ? bank_img[rd_bank_q] : '0;
  assign out_idx   = rd_idx_q;
  assign out_last  = out_valid && (rd_idx_q == IDX_F);
  assign out_frame = frame_q;

endmodule

// File: tb/tb_radix6_out_serializer.sv
// Self-checking bench: frames queued into a two-deep frame FIFO model and
// compared beat by beat against the serializer outputs.
module tb_radix6_out_serializer;
  import radix6_pkg::*;

  localparam int DATA_W  = 32;
  localparam int FRAME_W = 8;
  localparam int VW      = 1 + 2 * DATA_W + IDX_W + 1 + FRAME_W;

  typedef cplx_t [NPTS-1:0] frame_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_re;
  logic [DATA_W-1:0]  out_img;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic [FRAME_W-1:0] out_frame;
  frame_t             drv;
  logic               drv_gate;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  frame_t src_q[$];
  frame_t mdl_q[$];
  int     mdl_pos;
  int     mdl_frame;

  wire [VW-1:0] obs = {out_valid, out_re, out_img, out_idx, out_last, out_frame};

  always #5 clk = ~clk;

  radix6_out_serializer #(
    .DATA_W  (DATA_W),
    .FRAME_W (FRAME_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (drv[0].re),
    .b_re      (drv[1].re),
    .c_re      (drv[2].re),
    .d_re      (drv[3].re),
    .e_re      (drv[4].re),
    .f_re      (drv[5].re),
    .a_img     (drv[0].img),
    .b_img     (drv[1].img),
    .c_img     (drv[2].img),
    .d_img     (drv[3].img),
    .e_img     (drv[4].img),
    .f_img     (drv[5].img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_frame (out_frame)
  );

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NPTS; i++) begin
      f[i].re  = $urandom;
      f[i].img = $urandom;
    end
    return f;
  endfunction

  // Model: a FIFO of at most two frames; the head frame is emitted point by point.
  function automatic logic [VW-1:0] exp_vec();
    if (mdl_q.size() > 0)
      return {1'b1, mdl_q[0][mdl_pos].re, mdl_q[0][mdl_pos].img, IDX_W'(mdl_pos),
              mdl_pos == NPTS - 1, FRAME_W'(mdl_frame)};
    return {1'b0, {(2 * DATA_W){1'b0}}, {IDX_W{1'b0}}, 1'b0, FRAME_W'(mdl_frame)};
  endfunction

  function automatic logic exp_ready();
    return mdl_q.size() < 2;
  endfunction

  function automatic bit busy();
    return (src_q.size() > 0) || (mdl_q.size() > 0);
  endfunction

  task automatic mdl_reset();
    mdl_q.delete();
    src_q.delete();
    mdl_pos   = 0;
    mdl_frame = 0;
  endtask

  task automatic drive();
    in_valid = (src_q.size() > 0) && drv_gate;
    drv      = in_valid ? src_q[0] : rand_frame();
  endtask

  task automatic tick();
    bit fin, fout;
    @(posedge clk);
    cyc++;
    fin  = in_valid && (mdl_q.size() < 2);
    fout = out_ready && (mdl_q.size() > 0);
    if (fout) begin
      mdl_pos++;
      if (mdl_pos == NPTS) begin
        void'(mdl_q.pop_front());
        mdl_pos   = 0;
        mdl_frame = (mdl_frame + 1) % (1 << FRAME_W);
      end
    end
    if (fin) mdl_q.push_back(src_q.pop_front());
    #1;
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mdl_reset();
    drive();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drv_gate  = 1'b1;
    rst       = 1'b0;
    drv       = rand_frame();
    #3;
    rst = 1'b1;
    mdl_reset();
    #1;
    checks++;
    if ({out_valid, out_re, out_frame} !== '0) begin
      failures++;
      $display("FAIL reset_async got v=%b re=%h frame=%0d exp 0/0/0", out_valid, out_re, out_frame);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got rdy=%b obs=%h exp rdy=1 obs=%h", in_ready, obs, exp_vec());
    end
  endtask

  task automatic test_single_frame();
    frame_t f = rand_frame();
    int beats = 0, lasts = 0;
    f[0].re = 32'h3f491a30; f[0].img = 32'h4246570a;
    f[5].re = 32'hbf15c290; f[5].img = 32'h4246570a;
    src_q.push_back(f);
    out_ready = 1'b1;
    drive();
    for (int i = 0; i < 40 && busy(); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL single cyc=%0d got=%h rdy=%b exp=%h rdy=%b", cyc, obs, in_ready, exp_vec(), exp_ready());
      end
      if (out_valid && out_ready) beats++;
      if (out_last) begin
        lasts++;
        checks++;
        if (out_re !== 32'hbf15c290 || out_idx !== 3'd5) begin
          failures++;
          $display("FAIL single_last got re=%h idx=%0d exp re=bf15c290 idx=5", out_re, out_idx);
        end
      end
    end
    checks++;
    if (busy() || beats != 6 || lasts != 1) begin
      failures++;
      $display("FAIL single_count got beats=%0d lasts=%0d busy=%0d exp 6/1/0", beats, lasts, busy());
    end
  endtask

  task automatic test_back_to_back();
    int valid_cycles = 0, first = -1, last = -1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      frame_t f = rand_frame();
      if (k == 1) f[0].re = 32'hc142a3d7;
      src_q.push_back(f);
    end
    out_ready = 1'b1;
    drive();
    for (int i = 0; i < 80 && busy(); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h rdy=%b exp=%h rdy=%b", cyc, obs, in_ready, exp_vec(), exp_ready());
      end
      if (i == 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_full got in_ready=%b exp 0 after two captures", in_ready);
        end
      end
      if (out_valid) begin
        valid_cycles++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (busy() || valid_cycles != 24 || (last - first + 1) != 24) begin
      failures++;
      $display("FAIL b2b_bubbles got beats=%0d span=%0d busy=%0d exp 24/24/0", valid_cycles, last - first + 1, busy());
    end
  endtask

  task automatic test_backpressure();
    frame_t f = rand_frame();
    bit stalled = 1'b0, resumed = 1'b0;
    f[2].re = 32'hc14c0000; f[2].img = 32'h4246570a;
    src_q.push_back(f);
    out_ready = 1'b1;
    drive();
    for (int i = 0; i < 60 && busy(); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL bp cyc=%0d got=%h rdy=%b exp=%h rdy=%b", cyc, obs, in_ready, exp_vec(), exp_ready());
      end
      if (stalled && !resumed) begin
        resumed = 1'b1;
        checks++;
        if (out_idx !== 3'd3 || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_resume got idx=%0d v=%b exp idx=3 v=1", out_idx, out_valid);
        end
      end
      if (!stalled && mdl_q.size() > 0 && mdl_pos == 2) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (out_re !== 32'hc14c0000 || out_img !== 32'h4246570a || out_idx !== 3'd2 ||
              obs !== exp_vec()) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got re=%h img=%h idx=%0d exp re=c14c0000 img=4246570a idx=2",
                     cyc, out_re, out_img, out_idx);
          end
        end
        out_ready = 1'b1;
      end
    end
    checks++;
    if (busy() || !resumed) begin
      failures++;
      $display("FAIL bp_done got busy=%0d resumed=%0d exp 0/1", busy(), resumed);
    end
  endtask

  task automatic test_reset_mid();
    bit first_seen = 1'b0;
    do_reset();
    src_q.push_back(rand_frame());
    src_q.push_back(rand_frame());
    out_ready = 1'b1;
    drive();
    for (int i = 0; i < 40 && !(mdl_frame == 1 && mdl_pos == 3); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    mdl_reset();
    drive();
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL mid_async got v=%b obs=%h exp v=0 obs=%h", out_valid, obs, exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    src_q.push_back(rand_frame());
    drive();
    for (int i = 0; i < 40 && busy(); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL mid_post cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        checks++;
        if (out_idx !== 3'd0 || out_frame !== 8'd0) begin
          failures++;
          $display("FAIL mid_first got idx=%0d frame=%0d exp 0/0", out_idx, out_frame);
        end
      end
    end
    checks++;
    if (busy() || !first_seen) begin
      failures++;
      $display("FAIL mid_done got busy=%0d seen=%0d exp 0/1", busy(), first_seen);
    end
  endtask

  task automatic test_frame_wrap();
    bit seen_wrap = 1'b0, seen_nan = 1'b0;
    logic [FRAME_W-1:0] prev_frame = out_frame;
    for (int k = 0; k < 256; k++) begin
      frame_t f = rand_frame();
      if (k == 10) begin
        f[1].re = 32'h7fc00000; f[1].img = 32'h7f800000;
        f[3].re = 32'h80000000; f[4].img = 32'h00000001;
      end
      src_q.push_back(f);
    end
    for (int i = 0; i < 6000 && busy(); i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h rdy=%b exp=%h rdy=%b", cyc, obs, in_ready, exp_vec(), exp_ready());
      end
      if (prev_frame == 8'd255 && out_frame == 8'd0) seen_wrap = 1'b1;
      if (out_valid && out_idx == 3'd1 && out_re === 32'h7fc00000 && out_img === 32'h7f800000)
        seen_nan = 1'b1;
      prev_frame = out_frame;
      out_ready  = ($urandom_range(0, 4) != 0);
      drv_gate   = ($urandom_range(0, 3) != 0);
      drive();
    end
    checks++;
    if (busy() || !seen_wrap || !seen_nan) begin
      failures++;
      $display("FAIL wrap_done got busy=%0d wrap=%0d nan=%0d exp 0/1/1", busy(), seen_wrap, seen_nan);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
